accum_buffer_controller: RTL and testbench

//  Sequences the accumulation double buffer across a run of output tiles.

---
 rtl/accum_ctrl_pkg.sv | 25 ++
 rtl/accum_rd_valid_pipe.sv | 30 +++
 rtl/accum_buffer_controller.sv | 184 ++++++++++++++++++
 tb/tb_accum_buffer_controller.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_ctrl_pkg.sv
// rtl/accum_ctrl_pkg.sv - states, widths and helpers shared by the accumulation buffer controller
package accum_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    SWITCH,
    OVERLAP,
    DRAIN,
    FIN
  } state_e;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_NUM_OC     = 4;
  localparam int OUT_WIDTH      = DEF_DATA_WIDTH / DEF_NUM_OC;

  // Bits needed to count 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width = width + 1;
    return width;
  endfunction

endpackage

// File: rtl/accum_rd_valid_pipe.sv
// rtl/accum_rd_valid_pipe.sv - read-valid delay line tracking drain reads in flight
module accum_rd_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_i,
  output logic valid_o,
  output logic in_flight_o
);

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;

  // A new read enters stage 0 while older reads move one stage toward the output.
  always_comb begin
    stage_d    = stage_q << 1;
    stage_d[0] = valid_i;
  end

  // Reset doubles as the synchronous clear that squashes reads still in the pipe.
  always_ff @(posedge clk) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign valid_o     = stage_q[DEPTH-1];
  assign in_flight_o = |stage_q;

endmodule

// File: rtl/accum_buffer_controller.sv
// rtl/accum_buffer_controller.sv - double-buffer fill/drain sequencer; ACCUM_CTRL_PERF_EN adds perf_stall_cnt
module accum_buffer_controller
  import accum_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int BANK_ADDR_WIDTH = 32,
  parameter int NUM_OC          = 4,
  parameter int RD_LATENCY      = 2,
  parameter int TILE_CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [BANK_ADDR_WIDTH-1:0] num_words,
  input  logic [TILE_CNT_WIDTH-1:0]  num_tiles,
  input  logic                       acc_valid,
  output logic                       acc_ready,
  output logic                       wen,
  output logic [BANK_ADDR_WIDTH-1:0] wadr,
  output logic                       ren_out,
  output logic [BANK_ADDR_WIDTH-1:0] radr_out,
  output logic                       switch_banks,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       done
`ifdef ACCUM_CTRL_PERF_EN
  ,
  output logic [31:0]                perf_stall_cnt
`endif
);

  localparam int SUB_W = clog2(NUM_OC);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(NUM_OC - 1);

  // A buffer word must split evenly into NUM_OC output subwords.
  if ((DATA_WIDTH % NUM_OC) != 0) begin : g_bad_data_width
    $error("DATA_WIDTH must be a multiple of NUM_OC");
  end

  state_e                     state_q, state_d;
  logic [BANK_ADDR_WIDTH-1:0] num_words_q, fill_cnt_q, drain_adr_q, last_adr;
  logic [TILE_CNT_WIDTH-1:0]  num_tiles_q, tile_cnt_q;
  logic [TILE_CNT_WIDTH:0]    tiles_after_switch;
  logic [SUB_W-1:0]           sub_cnt_q;
  logic                       fill_done_q, drain_done_q, zero_done_q;
  logic                       start_ok, start_zero, more_tiles, draining, fin_pulse, in_flight;

  assign start_ok           = start && (num_words != '0) && (num_tiles != '0);
  assign start_zero         = start && !start_ok;
  assign last_adr           = num_words_q - 1'b1;
  assign tiles_after_switch = {1'b0, tile_cnt_q} + 1'b1;
  assign more_tiles         = tiles_after_switch < {1'b0, num_tiles_q};

  assign wen      = acc_valid && acc_ready;
  assign wadr     = fill_cnt_q;
  assign ren_out  = draining && out_ready && !drain_done_q;
  assign radr_out = drain_adr_q;
  assign done     = fin_pulse || zero_done_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-state control: which side fills, which drains, when banks swap.
  always_comb begin
    state_d      = state_q;
    acc_ready    = 1'b0;
    draining     = 1'b0;
    switch_banks = 1'b0;
    busy         = 1'b0;
    fin_pulse    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = FILL;
      end
      FILL: begin
        busy      = 1'b1;
        acc_ready = !fill_done_q;
        if (fill_done_q) state_d = SWITCH;
      end
      SWITCH: begin
        busy         = 1'b1;
        switch_banks = 1'b1;
        state_d      = more_tiles ? OVERLAP : DRAIN;
      end
      OVERLAP: begin
        busy      = 1'b1;
        acc_ready = !fill_done_q;
        draining  = 1'b1;
        if (fill_done_q && drain_done_q && !in_flight) state_d = SWITCH;
      end
      DRAIN: begin
        busy     = 1'b1;
        draining = 1'b1;
        if (drain_done_q && !in_flight) state_d = FIN;
      end
      FIN: begin
        fin_pulse = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Run parameters plus fill/drain counters; counters saturate at the last address
  // and a done flag marks completion, so addresses never pass num_words-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_words_q  <= '0;
      num_tiles_q  <= '0;
      tile_cnt_q   <= '0;
      fill_cnt_q   <= '0;
      fill_done_q  <= 1'b0;
      drain_adr_q  <= '0;
      sub_cnt_q    <= '0;
      drain_done_q <= 1'b0;
      zero_done_q  <= 1'b0;
    end else begin
      zero_done_q <= (state_q == IDLE) && start_zero;
      if ((state_q == IDLE) && start_ok) begin
        num_words_q  <= num_words;
        num_tiles_q  <= num_tiles;
        tile_cnt_q   <= '0;
        fill_cnt_q   <= '0;
        fill_done_q  <= 1'b0;
        drain_adr_q  <= '0;
        sub_cnt_q    <= '0;
        drain_done_q <= 1'b0;
      end else if (state_q == SWITCH) begin
        tile_cnt_q   <= tile_cnt_q + 1'b1;
        fill_cnt_q   <= '0;
        fill_done_q  <= 1'b0;
        drain_adr_q  <= '0;
        sub_cnt_q    <= '0;
        drain_done_q <= 1'b0;
      end else begin
        if (wen) begin
          if (fill_cnt_q == last_adr) fill_done_q <= 1'b1;
          else                        fill_cnt_q  <= fill_cnt_q + 1'b1;
        end
        if (ren_out) begin
          if (sub_cnt_q == SUB_LAST) begin
            sub_cnt_q <= '0;
            if (drain_adr_q == last_adr) drain_done_q <= 1'b1;
            else                         drain_adr_q  <= drain_adr_q + 1'b1;
          end else begin
            sub_cnt_q <= sub_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  accum_rd_valid_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_rd_valid_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (ren_out),
    .valid_o    (out_valid),
    .in_flight_o(in_flight)
  );

`ifdef ACCUM_CTRL_PERF_EN
  logic [31:0] perf_q;

  // Saturating count of overlap cycles where one side has finished and waits on the other.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if ((state_q == IDLE) && start_ok) begin
      perf_q <= '0;
    end else if ((state_q == OVERLAP) && (fill_done_q ^ drain_done_q) && (perf_q != '1)) begin
      perf_q <= perf_q + 1'b1;
    end
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_accum_buffer_controller.sv
// tb/tb_accum_buffer_controller.sv - scoreboard bench for accum_buffer_controller
module tb_accum_buffer_controller;

  localparam int BAW    = 32;
  localparam int TCW    = 16;
  localparam int NUM_OC = 4;
  localparam int RD_LAT = 2;

  logic           clk = 1'b0;
  logic           rst_n, start, acc_valid, out_ready;
  logic [BAW-1:0] num_words, wadr, radr_out;
  logic [TCW-1:0] num_tiles;
  logic           acc_ready, wen, ren_out, switch_banks, out_valid, busy, done;
`ifdef ACCUM_CTRL_PERF_EN
  logic [31:0]    perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  accum_buffer_controller #(
    .DATA_WIDTH(64), .BANK_ADDR_WIDTH(BAW), .NUM_OC(NUM_OC),
    .RD_LATENCY(RD_LAT), .TILE_CNT_WIDTH(TCW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words), .num_tiles(num_tiles),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .wen(wen), .wadr(wadr),
    .ren_out(ren_out), .radr_out(radr_out), .switch_banks(switch_banks),
    .out_ready(out_ready), .out_valid(out_valid), .busy(busy), .done(done)
`ifdef ACCUM_CTRL_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_wadr[$];
  int exp_radr[$];
  int wr_seen, rd_seen, ov_seen, sw_seen, done_seen;
  int exp_words, exp_tiles;
  int cyc_no = 0;
  int last_ov_cyc, done_cyc;
  bit overlap_seen;
  bit mon_en = 1'b0;
  bit ren_hist[RD_LAT];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc_no++;

  // Monitor: pops the expected write/drain address streams and checks run-level invariants.
  always @(negedge clk) begin
    if (mon_en) begin
      if (wen) begin
        if (exp_wadr.size() == 0) chk("wen_extra", 1, 0);
        else                      chk("wadr", wadr, exp_wadr.pop_front());
        wr_seen++;
      end
      if (ren_out) begin
        chk("ren_needs_out_ready", out_ready, 1);
        if (exp_radr.size() == 0) chk("ren_extra", 1, 0);
        else                      chk("radr", radr_out, exp_radr.pop_front());
        rd_seen++;
      end
      if (out_valid || ren_hist[RD_LAT-1]) chk("out_valid_latency", out_valid, ren_hist[RD_LAT-1]);
      if (out_valid) begin
        ov_seen++;
        last_ov_cyc = cyc_no;
      end
      for (int i = RD_LAT - 1; i > 0; i--) ren_hist[i] = ren_hist[i-1];
      ren_hist[0] = ren_out;
      if (wen && ren_out) overlap_seen = 1'b1;
      if (switch_banks) begin
        sw_seen++;
        chk("switch_after_full_fill", wr_seen, exp_words * sw_seen);
        chk("switch_after_full_drain", rd_seen, exp_words * NUM_OC * (sw_seen - 1));
        chk("switch_no_inflight", ov_seen, rd_seen);
      end
      if (done) begin
        done_seen++;
        done_cyc = cyc_no;
        chk("done_writes", wr_seen, exp_tiles * exp_words);
        chk("done_reads", rd_seen, exp_tiles * exp_words * NUM_OC);
        chk("done_valids", ov_seen, rd_seen);
        chk("done_switches", sw_seen, exp_tiles);
        chk("done_busy_low", busy, 0);
      end
    end
  end

  // Reference model: every tile writes 0..W-1 once and drains each address NUM_OC times.
  task automatic setup(input int w, input int t);
    exp_wadr.delete();
    exp_radr.delete();
    wr_seen = 0; rd_seen = 0; ov_seen = 0; sw_seen = 0; done_seen = 0;
    overlap_seen = 1'b0;
    for (int i = 0; i < RD_LAT; i++) ren_hist[i] = 1'b0;
    exp_words = w;
    exp_tiles = t;
    for (int k = 0; k < t; k++)
      for (int a = 0; a < w; a++) begin
        exp_wadr.push_back(a);
        for (int s = 0; s < NUM_OC; s++) exp_radr.push_back(a);
      end
    mon_en = 1'b1;
  endtask

  task automatic drive(input int mode, input int c);
    case (mode)
      0: begin acc_valid = 1'b1; out_ready = 1'b1; end
      1: begin acc_valid = ($urandom_range(0, 3) != 0); out_ready = ($urandom_range(0, 3) != 0); end
      2: begin acc_valid = 1'b1; out_ready = !(c >= 8 && c < 13); end
      default: begin acc_valid = !(c >= 6 && c < 40); out_ready = 1'b1; end
    endcase
  endtask

  task automatic run(input int w, input int t, input int mode, input bit mid_start);
    int c;
    setup(w, t);
    @(posedge clk); #1;
    num_words = BAW'(w);
    num_tiles = TCW'(t);
    start     = 1'b1;
    drive(mode, 0);
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (done_seen == 0 && c < 5000) begin
      drive(mode, c);
      if (mid_start && c == 10 && busy) begin
        start = 1'b1; num_words = 7; num_tiles = 1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    if (done_seen == 0) chk("run_timeout", 0, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("done_once", done_seen, 1);
    chk("wadr_left", exp_wadr.size(), 0);
    chk("radr_left", exp_radr.size(), 0);
    mon_en = 1'b0;
  endtask

  task automatic zero_start(input int w, input int t);
    setup(w, 0);
    @(posedge clk); #1;
    num_words = BAW'(w);
    num_tiles = TCW'(t);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("zero_done_next_cycle", done, 1);
    chk("zero_not_busy", busy, 0);
    @(negedge clk);
    chk("zero_done_one_cycle", done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("zero_done_once", done_seen, 1);
    mon_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n = 1'b0; start = 1'b0; acc_valid = 1'b1; out_ready = 1'b1;
    num_words = '0; num_tiles = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_acc_ready", acc_ready, 0);
    chk("rst_wen", wen, 0);
    chk("rst_ren", ren_out, 0);
    chk("rst_switch", switch_banks, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wadr", wadr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run(3, 1, 0, 1'b0);
    chk("single_tile_done_gap_ok", (done_cyc - last_ov_cyc >= 1) && (done_cyc - last_ov_cyc <= 2), 1);
    chk("single_tile_valids", ov_seen, 12);

    run(4, 3, 0, 1'b0);
    chk("three_tile_overlap", overlap_seen, 1);
    chk("three_tile_valids", ov_seen, 48);

    run(3, 1, 2, 1'b0);
    run(4, 2, 3, 1'b0);
`ifdef ACCUM_CTRL_PERF_EN
    chk("perf_stall_nonzero", perf_stall_cnt != 0, 1);
`endif

    run(6, 3, 1, 1'b1);
    for (int r = 0; r < 5; r++) run($urandom_range(1, 6), $urandom_range(1, 4), 1, 1'b0);

    zero_start(5, 0);
    zero_start(0, 3);

    // Reset pulse while overlapping fill of tile 2 with drain of tile 1.
    setup(4, 3);
    @(posedge clk); #1;
    num_words = 4; num_tiles = 3; start = 1'b1; drive(0, 0);
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (sw_seen == 0 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_pre_busy", busy, 1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_acc_ready", acc_ready, 0);
    chk("rst_mid_wen", wen, 0);
    chk("rst_mid_ren", ren_out, 0);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid_no_switch", switch_banks, 0);
      chk("rst_mid_no_done", done, 0);
      @(negedge clk);
    end

    run(2, 2, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
